// File: rtl/reg_file_8x32_pkg.sv
// Shared sizing and index type for the 8-entry register file and its decoders.
package reg_file_8x32_pkg;
   localparam int REG_ADDR_W   = 3;
   localparam int NUM_REGS     = 8;
   localparam int DEF_DATA_W   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_8x32_decoder.sv
// One-hot 3-to-8 decoder with enable; a is the MSB of the index, c the LSB.
module three_to_eight_decoder (
   output logic [7:0] out,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       en
);
   always_comb begin
      out = 8'h00;
      if (en) out = 8'h01 << {a, b, c};
   end
endmodule

// File: rtl/reg_file_8x32.sv
// Eight-entry register file with a per-register busy scoreboard and two
// combinational read ports with optional writeback bypass.
module reg_file_8x32
   import reg_file_8x32_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter bit ZERO_REG0 = 1'b1,
   parameter bit BYPASS    = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_en,
   input  reg_addr_t         wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              iss_en,
   input  reg_addr_t         iss_addr,
   input  reg_addr_t         ra_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic              ra_busy,
   input  reg_addr_t         rb_addr,
   output logic [DATA_W-1:0] rb_data,
   output logic              rb_busy,
   output logic [NUM_REGS-1:0] busy_vec
);
   logic [NUM_REGS-1:0] we;
   logic [NUM_REGS-1:0] set;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                ra_zero, rb_zero, ra_hit, rb_hit;

   three_to_eight_decoder u_wb_dec (
      .out (we),
      .a   (wb_addr[2]),
      .b   (wb_addr[1]),
      .c   (wb_addr[0]),
      .en  (wb_en)
   );

   three_to_eight_decoder u_iss_dec (
      .out (set),
      .a   (iss_addr[2]),
      .b   (iss_addr[1]),
      .c   (iss_addr[0]),
      .en  (iss_en)
   );

   // Set is ORed in after the clear so a new producer keeps ownership.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (we[i] && !(ZERO_REG0 && i == 0)) regs_d[i] = wb_data;
         busy_d[i] = set[i] | (busy_q[i] & ~we[i]);
      end
      if (ZERO_REG0) busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         busy_q <= busy_d;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      end
   end

   always_comb begin
      ra_zero = ZERO_REG0 && (ra_addr == '0);
      rb_zero = ZERO_REG0 && (rb_addr == '0);
      ra_hit  = BYPASS && wb_en && (wb_addr == ra_addr) && !ra_zero;
      rb_hit  = BYPASS && wb_en && (wb_addr == rb_addr) && !rb_zero;

      if (ra_zero)     ra_data = '0;
      else if (ra_hit) ra_data = wb_data;
      else             ra_data = regs_q[ra_addr];

      if (rb_zero)     rb_data = '0;
      else if (rb_hit) rb_data = wb_data;
      else             rb_data = regs_q[rb_addr];

      ra_busy = ra_hit ? 1'b0 : busy_q[ra_addr];
      rb_busy = rb_hit ? 1'b0 : busy_q[rb_addr];
   end

   assign busy_vec = busy_q;
endmodule

// File: tb/tb_reg_file_8x32.sv
// Randomized and directed bench for reg_file_8x32 against an array-based model.
module tb_reg_file_8x32;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_en, iss_en;
   logic [2:0]  wb_addr, iss_addr, ra_addr, rb_addr;
   logic [31:0] wb_data;
   logic [31:0] ra_data, rb_data;
   logic        ra_busy, rb_busy;
   logic [7:0]  busy_vec;

   logic [31:0] m_regs [8];
   logic        m_busy [8];
   int          n_checks = 0;
   int          n_fails  = 0;

   always #5 clk = ~clk;

   reg_file_8x32 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .ra_addr  (ra_addr),
      .ra_data  (ra_data),
      .ra_busy  (ra_busy),
      .rb_addr  (rb_addr),
      .rb_data  (rb_data),
      .rb_busy  (rb_busy),
      .busy_vec (busy_vec)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_data(input logic [2:0] a);
      if (a == 3'd0) return 32'h0;
      if (wb_en && wb_addr == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [2:0] a);
      if (wb_en && wb_addr == a) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic logic [7:0] exp_vec();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_regs[i] = 32'h0;
         m_busy[i] = 1'b0;
      end
   endtask

   task automatic check_reads();
      check("ra_data", ra_data, exp_data(ra_addr));
      check("ra_busy", {31'h0, ra_busy}, {31'h0, exp_busy(ra_addr)});
      check("rb_data", rb_data, exp_data(rb_addr));
      check("rb_busy", {31'h0, rb_busy}, {31'h0, exp_busy(rb_addr)});
      check("busy_vec", {24'h0, busy_vec}, {24'h0, exp_vec()});
   endtask

   // Entered just after a rising edge; leaves 1 ns after the next one.
   task automatic step(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [2:0] ia,
                       input logic [2:0] ra, input logic [2:0] rb);
      wb_en = we; wb_addr = wa; wb_data = wd;
      iss_en = ie; iss_addr = ia; ra_addr = ra; rb_addr = rb;
      #2;
      check_reads();
      @(posedge clk);
      if (we && wa != 3'd0) m_regs[wa] = wd;
      if (we) m_busy[wa] = 1'b0;
      if (ie && ia != 3'd0) m_busy[ia] = 1'b1;
      #1;
   endtask

   task automatic idle();
      wb_en = 1'b0; iss_en = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; wb_en = 1'b0; iss_en = 1'b0;
      wb_addr = '0; iss_addr = '0; wb_data = '0; ra_addr = '0; rb_addr = '0;
      model_reset();
      #2;
      for (int i = 0; i < 8; i++) begin
         ra_addr = 3'(i); rb_addr = 3'(7 - i);
         #1;
         check("rst_ra_data", ra_data, 32'h0);
         check("rst_rb_data", rb_data, 32'h0);
         check("rst_ra_busy", {31'h0, ra_busy}, 32'h0);
         check("rst_rb_busy", {31'h0, rb_busy}, 32'h0);
      end
      check("rst_busy_vec", {24'h0, busy_vec}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      step(1'b0, 3'd0, 32'h0, 1'b1, 3'd5, 3'd5, 3'd0);
      check("iss5_busy_vec", {24'h0, busy_vec}, 32'h20);
      step(1'b1, 3'd5, 32'hDEADBEEF, 1'b0, 3'd0, 3'd5, 3'd5);
      idle(); ra_addr = 3'd5; #1;
      check("wb5_busy_vec", {24'h0, busy_vec}, 32'h0);
      check("wb5_ra_data", ra_data, 32'hDEADBEEF);

      step(1'b1, 3'd3, 32'h1, 1'b0, 3'd0, 3'd3, 3'd1);
      step(1'b0, 3'd0, 32'h0, 1'b1, 3'd3, 3'd3, 3'd1);
      wb_en = 1'b1; wb_addr = 3'd3; wb_data = 32'h12345678; ra_addr = 3'd3; #1;
      check("byp_ra_data", ra_data, 32'h12345678);
      check("byp_ra_busy", {31'h0, ra_busy}, 32'h0);
      step(1'b1, 3'd3, 32'h12345678, 1'b0, 3'd0, 3'd3, 3'd3);

      step(1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 3'd2, 3'd2);
      step(1'b1, 3'd2, 32'hCAFE0002, 1'b1, 3'd2, 3'd2, 3'd4);
      idle(); ra_addr = 3'd2; #1;
      check("setwins_busy2", {31'h0, busy_vec[2]}, 32'h1);
      check("setwins_data2", ra_data, 32'hCAFE0002);

      step(1'b1, 3'd0, 32'hFFFFFFFF, 1'b0, 3'd0, 3'd0, 3'd0);
      step(1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 3'd0, 3'd0);
      idle(); ra_addr = 3'd0; #1;
      check("r0_data", ra_data, 32'h0);
      check("r0_busy", {31'h0, busy_vec[0]}, 32'h0);

      for (int n = 0; n < 400; n++)
         step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

      // Mid-cycle reset with an issue and a writeback both presented.
      wb_en = 1'b1; wb_addr = 3'd1; wb_data = 32'hA5A5A5A5;
      iss_en = 1'b1; iss_addr = 3'd6;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mrst_busy_vec", {24'h0, busy_vec}, 32'h0);
      idle();
      for (int i = 0; i < 8; i++) begin
         ra_addr = 3'(i); rb_addr = 3'(i);
         #1;
         check("mrst_ra_data", ra_data, 32'h0);
         check("mrst_rb_busy", {31'h0, rb_busy}, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      ra_addr = 3'd1; #1;
      check("mrst_wb_lost", ra_data, 32'h0);
      for (int n = 0; n < 50; n++)
         step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
